ldpc_dec: RTL and testbench
===========================

LDPC_DEC -- requirements
Module: ldpc_dec

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide ZC, 64, lifting size (LLRs per sub-block).
REQ-002 SHALL provide VWIDTH, 8, LLR width in bits (two's complement).
REQ-003 SHALL provide DECOUT_LIFTING, 8, sub-blocks per output beat.
REQ-004 SHALL provide APP_ADDR_WIDTH, 6, width of the address-bound inputs.

Ports (name, direction, width, meaning):
REQ-005 SHALL have clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have rst_n, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have APPmsg_ini_subx_0 .. APPmsg_ini_subx_7, input, ZC*VWIDTH each, the eight initial-LLR sub-blocks of the current group; LLR z is at bits [z*VWIDTH +: VWIDTH].
REQ-008 SHALL have APPmsg_ini_sub_x, input, 2, index (0-3) of the group presented.
REQ-009 SHALL have buffer_valid, input, 1, load beat valid.
REQ-010 SHALL have buffer_start, input, 1, first beat of a frame.
REQ-011 SHALL have buffer_last, input, 1, final load beat.
REQ-012 SHALL have iLs, input, 3, code-rate mode: 2 selects 7/8 (3 groups); any other value selects 2/3 (4 groups).
REQ-013 SHALL have jLs, input, 3, iteration count.
REQ-014 SHALL have P, input, 6, cycles per iteration.
REQ-015 SHALL have APP_addr_max, input, APP_ADDR_WIDTH, and APP_addr_rd_max, input, APP_ADDR_WIDTH-1; both are sampled on buffer_start, reserved, and have no functional effect.
REQ-016 SHALL have buffer_ready, output, 1, core idle and able to accept a frame.
REQ-017 SHALL have decode_valid, output, 1, output beat valid.
REQ-018 SHALL have decode_valid_cnt, output, 3, index of the current output beat.
REQ-019 SHALL have APPmsg_decode_out, output, ZC*DECOUT_LIFTING, hard-decision bits.

Function
REQ-020 SHALL implement states IDLE, LOAD, DECODE and OUT.
REQ-021 In IDLE, buffer_ready SHALL be 1; in all other states it SHALL be 0 (registered).
REQ-022 IDLE->LOAD SHALL occur on buffer_valid&&buffer_start: clear all four group stores to 0, write the presented group, and latch the group count N (3 if iLs==2, else 4).
REQ-023 In LOAD, each buffer_valid cycle SHALL overwrite group store [APPmsg_ini_sub_x] with the 8 sub-blocks; repeated writes to the same group are legal, and the last write wins.
REQ-024 In LOAD, buffer_valid&&buffer_last SHALL write that beat, then go to DECODE; if asserted on the start beat, the transition SHALL happen immediately.
REQ-025 buffer_start with buffer_valid in LOAD SHALL restart the frame per REQ-022.
REQ-026 DECODE SHALL last exactly max(jLs*P,1) cycles, using an 8-bit product with jLs/P latched at start, then go to OUT.
REQ-027 OUT SHALL last N consecutive cycles with decode_valid=1 and decode_valid_cnt=0..N-1; beat g SHALL set bit [c*ZC+z] to the sign bit (MSB) of LLR z of sub-block c of group g.
REQ-028 After the last OUT beat, the core SHALL enter IDLE, and buffer_ready SHALL return to 1 the next cycle.
REQ-029 Outside OUT, decode_valid SHALL be 0; decode_valid_cnt and APPmsg_decode_out SHALL hold their last values.
REQ-030 buffer_valid, buffer_start and buffer_last SHALL be ignored in IDLE (without start), DECODE and OUT; buffer_last without buffer_valid SHALL be ignored.
REQ-031 Groups not written during the frame SHALL output all-zero beats.

Reset
REQ-032 rst_n low at any time SHALL immediately force IDLE and clear the group stores, buffer_ready=1, decode_valid=0, decode_valid_cnt=0 and APPmsg_decode_out=0; a mid-frame reset discards the frame.

Verification
REQ-033 Reset then release, with iLs=1 -> buffer_ready=1, decode_valid=0 and outputs 0.
REQ-034 iLs=1, jLs=1, P=32; load groups 0-3 (group g, all LLRs = -(g+1)) with start on the first beat and last on group 3 -> after 32 DECODE cycles, 4 beats, cnt 0..3, each all-ones.
REQ-035 iLs=2, groups 0-2 with LLR +5, group 1 re-written with -1 -> 3 beats: 0x0..0, all-ones, 0x0..0.
REQ-036 jLs=0 -> DECODE lasts 1 cycle; a load with only group 0 written under iLs=1 -> beats 1-3 all zero.
REQ-037 Assert rst_n low during DECODE -> immediate IDLE, no decode_valid, buffer_ready=1.
REQ-038 Assert buffer_start mid-LOAD -> stores cleared and frame restarted; output reflects only the post-restart data.

Source files
------------

// File: rtl/ldpc_dec.sv
// LDPC decoder shell: buffers four groups of initial LLR sub-blocks, waits a
// programmable number of decode cycles, then emits the hard decisions of each
// group as one output beat per group.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for a start beat; buffer_ready high
// S_LOAD   | accepting group beats until the last beat
// S_DECODE | down-counter runs for max(jLs*P,1) cycles (8-bit product)
// S_OUT    | one output beat per group, decode_valid high
module ldpc_dec #(
  parameter int ZC             = 64,
  parameter int VWIDTH         = 8,
  parameter int DECOUT_LIFTING = 8,
  parameter int APP_ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_0,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_1,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_2,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_3,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_4,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_5,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_6,
  input  logic [ZC*VWIDTH-1:0]         APPmsg_ini_subx_7,
  input  logic [1:0]                   APPmsg_ini_sub_x,
  input  logic                         buffer_valid,
  input  logic                         buffer_start,
  input  logic                         buffer_last,
  input  logic [2:0]                   iLs,
  input  logic [2:0]                   jLs,
  input  logic [5:0]                   P,
  input  logic [APP_ADDR_WIDTH-1:0]    APP_addr_max,
  input  logic [APP_ADDR_WIDTH-2:0]    APP_addr_rd_max,
  output logic                         buffer_ready,
  output logic                         decode_valid,
  output logic [2:0]                   decode_valid_cnt,
  output logic [ZC*DECOUT_LIFTING-1:0] APPmsg_decode_out
);

  localparam int SW = ZC * DECOUT_LIFTING;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [ZC*VWIDTH-1:0] sub_in [8];

  assign sub_in[0] = APPmsg_ini_subx_0;
  assign sub_in[1] = APPmsg_ini_subx_1;
  assign sub_in[2] = APPmsg_ini_subx_2;
  assign sub_in[3] = APPmsg_ini_subx_3;
  assign sub_in[4] = APPmsg_ini_subx_4;
  assign sub_in[5] = APPmsg_ini_subx_5;
  assign sub_in[6] = APPmsg_ini_subx_6;
  assign sub_in[7] = APPmsg_ini_subx_7;

  // Only the hard decisions are ever observable, so the group stores keep
  // just the sign bit of each LLR.
  logic [SW-1:0] beat_sign;

  // Gather the sign bit of every LLR in the presented beat
  always_comb begin
    beat_sign = '0;
    for (int c = 0; c < DECOUT_LIFTING; c++) begin
      for (int z = 0; z < ZC; z++) begin
        beat_sign[c*ZC+z] = sub_in[c][z*VWIDTH+VWIDTH-1];
      end
    end
  end

  logic [1:0]                state_q, state_d;
  logic [SW-1:0]             store_q [4];
  logic [SW-1:0]             store_d [4];
  logic [2:0]                ngrp_q, ngrp_d;
  logic [2:0]                jls_q, jls_d;
  logic [5:0]                p_q, p_d;
  logic [7:0]                timer_q, timer_d;
  logic [1:0]                beat_q, beat_d;
  logic [APP_ADDR_WIDTH-1:0] addr_max_q, addr_max_d;
  logic [APP_ADDR_WIDTH-2:0] addr_rd_max_q, addr_rd_max_d;

  logic          ready_q, ready_d;
  logic          dv_q, dv_d;
  logic [2:0]    dvc_q, dvc_d;
  logic [SW-1:0] dout_q, dout_d;

  logic       start_beat;
  logic [2:0] jls_src;
  logic [5:0] p_src;
  logic [7:0] prod;
  logic [7:0] dec_len;

  assign start_beat = buffer_valid & buffer_start;

  // A last beat that is also the start beat must use the live jLs/P values,
  // since they are only being latched on that same edge.
  assign jls_src = start_beat ? jLs : jls_q;
  assign p_src   = start_beat ? P   : p_q;
  assign prod    = {5'b0, jls_src} * {2'b0, p_src};
  assign dec_len = (prod == 8'd0) ? 8'd1 : prod;

  // Frame sequencing: load, decode timer, output beat counter
  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    ngrp_d        = ngrp_q;
    jls_d         = jls_q;
    p_d           = p_q;
    timer_d       = timer_q;
    beat_d        = beat_q;
    addr_max_d    = addr_max_q;
    addr_rd_max_d = addr_rd_max_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (start_beat) begin
          store_d       = '{default: '0};
          ngrp_d        = (iLs == 3'd2) ? 3'd3 : 3'd4;
          jls_d         = jLs;
          p_d           = P;
          addr_max_d    = APP_addr_max;
          addr_rd_max_d = APP_addr_rd_max;
          state_d       = S_LOAD;
        end
        if (buffer_valid && (start_beat || (state_q == S_LOAD))) begin
          store_d[APPmsg_ini_sub_x] = beat_sign;
          if (buffer_last) begin
            state_d = S_DECODE;
            timer_d = dec_len;
          end
        end
      end
      S_DECODE: begin
        if (timer_q == 8'd1) begin
          state_d = S_OUT;
          beat_d  = 2'd0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_OUT: begin
        if ({1'b0, beat_q} == (ngrp_q - 3'd1)) begin
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers follow the next state so they line up with the FSM
  always_comb begin
    ready_d = (state_d == S_IDLE);
    dv_d    = (state_d == S_OUT);
    dvc_d   = dvc_q;
    dout_d  = dout_q;
    if (state_d == S_OUT) begin
      dvc_d  = {1'b0, beat_d};
      dout_d = store_q[beat_d];
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ngrp_q        <= 3'd4;
      jls_q         <= '0;
      p_q           <= '0;
      timer_q       <= '0;
      beat_q        <= '0;
      addr_max_q    <= '0;
      addr_rd_max_q <= '0;
    end else begin
      state_q       <= state_d;
      ngrp_q        <= ngrp_d;
      jls_q         <= jls_d;
      p_q           <= p_d;
      timer_q       <= timer_d;
      beat_q        <= beat_d;
      addr_max_q    <= addr_max_d;
      addr_rd_max_q <= addr_rd_max_d;
    end
  end

  // Group stores of hard decisions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= '{default: '0};
    end else begin
      store_q <= store_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      dv_q    <= 1'b0;
      dvc_q   <= '0;
      dout_q  <= '0;
    end else begin
      ready_q <= ready_d;
      dv_q    <= dv_d;
      dvc_q   <= dvc_d;
      dout_q  <= dout_d;
    end
  end

  assign buffer_ready      = ready_q;
  assign decode_valid      = dv_q;
  assign decode_valid_cnt  = dvc_q;
  assign APPmsg_decode_out = dout_q;

  // Reserved address bounds and LLR magnitude bits have no functional use
  logic unused_ok;
  assign unused_ok = ^{addr_max_q, addr_rd_max_q,
                       sub_in[0], sub_in[1], sub_in[2], sub_in[3],
                       sub_in[4], sub_in[5], sub_in[6], sub_in[7]};

endmodule

// File: tb/tb_ldpc_dec.sv
// Self-checking bench for ldpc_dec: directed frames with literal expectations
// plus randomized frames checked every cycle against a behavioural model.
module tb_ldpc_dec;
  localparam int ZC  = 64;
  localparam int VW  = 8;
  localparam int SW  = 512;
  localparam int BIG = 1000000000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [ZC*VW-1:0] subx [8];
  logic [1:0]    sub_x;
  logic          valid, start, last;
  logic [2:0]    iLs, jLs;
  logic [5:0]    P;
  logic [5:0]    addr_max;
  logic [4:0]    addr_rd_max;
  logic          ready, dv;
  logic [2:0]    dvc;
  logic [SW-1:0] dout;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // Behavioural model: LLR values per group, plus the cycle windows of the
  // current frame derived from the timing rules.
  byte           m_llr [4][8][64];
  int            busy_from = 0, busy_to = 0, out_start = BIG;
  int            m_n = 4, m_len = 1, last_edge = 0;
  int            m_held_cnt = 0;
  logic [SW-1:0] m_held_data = '0;
  bit            cmp_en = 1'b1;
  bit            lit_en = 1'b0;
  logic [SW-1:0] lit_beats [4];
  int            obs_first = -1, obs_beats = 0;
  logic          dv_prev = 1'b0;

  ldpc_dec dut (
    .clk(clk), .rst_n(rst_n),
    .APPmsg_ini_subx_0(subx[0]), .APPmsg_ini_subx_1(subx[1]),
    .APPmsg_ini_subx_2(subx[2]), .APPmsg_ini_subx_3(subx[3]),
    .APPmsg_ini_subx_4(subx[4]), .APPmsg_ini_subx_5(subx[5]),
    .APPmsg_ini_subx_6(subx[6]), .APPmsg_ini_subx_7(subx[7]),
    .APPmsg_ini_sub_x(sub_x), .buffer_valid(valid), .buffer_start(start),
    .buffer_last(last), .iLs(iLs), .jLs(jLs), .P(P),
    .APP_addr_max(addr_max), .APP_addr_rd_max(addr_rd_max),
    .buffer_ready(ready), .decode_valid(dv), .decode_valid_cnt(dvc),
    .APPmsg_decode_out(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] hard(input int g);
    logic [SW-1:0] r;
    r = '0;
    for (int c = 0; c < 8; c++)
      for (int z = 0; z < ZC; z++)
        r[c*ZC+z] = (m_llr[g][c][z] < 0);
    return r;
  endfunction

  // Per-cycle comparison against the model
  always @(posedge clk) begin : cmp_blk
    bit in_out;
    int k;
    #1;
    if (cmp_en) begin
      in_out = (cyc >= out_start) && (cyc < out_start + m_n);
      k = cyc - out_start;
      chk("buffer_ready", ready, (cyc >= busy_from && cyc < busy_to) ? 0 : 1);
      chk("decode_valid", dv, in_out);
      if (in_out) begin
        m_held_cnt  = k;
        m_held_data = hard(k);
      end
      chk("decode_valid_cnt", dvc, m_held_cnt);
      chk("decode_out", dout, m_held_data);
      if (in_out && lit_en) chk("literal_beat", dout, lit_beats[k]);
      if (dv && !dv_prev) obs_first = cyc;
      if (dv) obs_beats++;
    end
    dv_prev = dv;
  end

  // One load beat; mode 0 = every LLR equals val, otherwise random LLRs
  task automatic beat(input int g, input bit st, input bit ls, input int mode, input int val);
    @(negedge clk);
    if (st) begin
      for (int a = 0; a < 4; a++)
        for (int c = 0; c < 8; c++)
          for (int z = 0; z < ZC; z++)
            m_llr[a][c][z] = 0;
      busy_from = cyc + 1;
      busy_to   = BIG;
      out_start = BIG;
      m_n   = (iLs == 3'd2) ? 3 : 4;
      m_len = (int'(jLs) * int'(P)) % 256;
      if (m_len == 0) m_len = 1;
      obs_first = -1;
      obs_beats = 0;
    end
    for (int c = 0; c < 8; c++) begin
      for (int z = 0; z < ZC; z++) begin
        byte v;
        v = (mode == 0) ? byte'(val) : byte'($urandom);
        subx[c][z*8 +: 8] = v;
        m_llr[g][c][z] = v;
      end
    end
    sub_x = 2'(g);
    valid = 1'b1;
    start = st;
    last  = ls;
    if (ls) begin
      last_edge = cyc + 1;
      out_start = last_edge + m_len;
      busy_to   = out_start + m_n;
    end
  endtask

  task automatic clean();
    valid = 1'b0;
    start = 1'b0;
    last  = 1'b0;
  endtask

  // Idle load cycles: start/last without valid must be ignored
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      start = 1'($urandom);
      last  = 1'($urandom);
      sub_x = 2'($urandom);
    end
  endtask

  // Drive junk while decoding/outputting, then settle in idle
  task automatic finish_frame();
    while (cyc < busy_to) begin
      @(negedge clk);
      if (cyc + 1 <= busy_to) begin
        valid   = 1'($urandom);
        start   = 1'($urandom);
        last    = 1'($urandom);
        sub_x   = 2'($urandom);
        subx[0] = {16{$urandom}};
      end else begin
        clean();
      end
    end
  endtask

  task automatic check_lit(input int len, input int n);
    chk("decode_length", obs_first - last_edge, len);
    chk("beat_count", obs_beats, n);
  endtask

  initial begin
    for (int c = 0; c < 8; c++) subx[c] = '0;
    sub_x = 0; clean();
    iLs = 3'd1; jLs = 3'd1; P = 6'd32;
    addr_max = 6'($urandom); addr_rd_max = 5'($urandom);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_valid", dv, 0);
    chk("reset_cnt", dvc, 0);
    chk("reset_out", dout, 0);
    @(negedge clk);

    // Four groups of negative LLRs, 32 decode cycles
    iLs = 3'd1; jLs = 3'd1; P = 6'd32;
    lit_en = 1'b1;
    for (int i = 0; i < 4; i++) lit_beats[i] = '1;
    beat(0, 1, 0, 0, -1);
    beat(1, 0, 0, 0, -2);
    beat(2, 0, 0, 0, -3);
    beat(3, 0, 1, 0, -4);
    finish_frame();
    check_lit(32, 4);

    // Rate 7/8, group 1 rewritten negative
    iLs = 3'd2; jLs = 3'd3; P = 6'd5;
    lit_beats[0] = '0; lit_beats[1] = '1; lit_beats[2] = '0;
    beat(0, 1, 0, 0, 5);
    beat(1, 0, 0, 0, 5);
    beat(2, 0, 0, 0, 5);
    beat(1, 0, 1, 0, -1);
    finish_frame();
    check_lit(15, 3);

    // jLs=0: single decode cycle, start and last on one beat
    iLs = 3'd1; jLs = 3'd0; P = 6'd17;
    lit_beats[0] = '1; lit_beats[1] = '0; lit_beats[2] = '0; lit_beats[3] = '0;
    beat(0, 1, 1, 0, -1);
    finish_frame();
    check_lit(1, 4);

    // Restart mid-load discards earlier groups
    iLs = 3'd0; jLs = 3'd2; P = 6'd3;
    lit_beats[0] = '0; lit_beats[1] = '0; lit_beats[2] = '0; lit_beats[3] = '1;
    beat(0, 1, 0, 0, -1);
    beat(1, 0, 0, 0, -1);
    gap(1);
    beat(2, 1, 0, 0, 3);
    beat(3, 0, 1, 0, -2);
    finish_frame();
    check_lit(6, 4);
    lit_en = 1'b0;

    // Reset during decode
    iLs = 3'd1; jLs = 3'd7; P = 6'd20;
    beat(0, 1, 0, 1, 0);
    beat(1, 0, 1, 1, 0);
    repeat (5) begin @(negedge clk); clean(); end
    rst_n = 1'b0;
    busy_from = 0; busy_to = 0; out_start = BIG;
    m_held_cnt = 0; m_held_data = '0;
    obs_beats = 0;
    #1;
    chk("midreset_ready", ready, 1);
    chk("midreset_valid", dv, 0);
    chk("midreset_out", dout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (160) @(negedge clk);
    chk("no_beats_after_reset", obs_beats, 0);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      int nb;
      iLs = 3'($urandom_range(0, 7));
      jLs = 3'($urandom_range(0, 7));
      P   = 6'($urandom_range(0, 63));
      addr_max = 6'($urandom); addr_rd_max = 5'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        valid = 1'b1; start = 1'b0; last = 1'($urandom);
      end
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        bit st, ls;
        st = (b == 0) || ($urandom_range(0, 5) == 0);
        ls = (b == nb - 1);
        beat($urandom_range(0, 3), st, ls, 1, 0);
        if (!ls && $urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
      end
      finish_frame();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
